// File: rtl/mlp_io_pkg.sv
// mlp_io_pkg: shared constants and types for the Pendigits MLP stream frontend.
package mlp_io_pkg;
  localparam int NUM_A = 16;
  localparam int WIDTH_A = 4;
  localparam int OUTWIDTH = 4;
  typedef enum logic [1:0] {LOAD, SETTLE, RESULT} state_t;
  typedef logic [WIDTH_A-1:0] feat_t;
endpackage

// File: rtl/mlp_stream_frontend.sv
// mlp_stream_frontend: assembles a feature stream into the classifier input, waits a settle
// window, then returns the captured class over a valid/ready handshake.
module mlp_stream_frontend
  import mlp_io_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         in_data,
  input  logic                       in_last,
  output logic [NUM_A*WIDTH_A-1:0]   cls_inp,
  input  logic [OUTWIDTH-1:0]        cls_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUTWIDTH-1:0]        out_class,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           sample_cnt
);
  localparam int IDX_W = $clog2(NUM_A);
  localparam int SC_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_A - 1);
  localparam logic [SC_W-1:0] CNT_LAST = SC_W'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SC_W-1:0] cnt_q, cnt_d;
  feat_t feat_q [NUM_A];
  feat_t feat_d [NUM_A];
  logic out_valid_q, out_valid_d;
  logic [OUTWIDTH-1:0] out_class_q, out_class_d;
  logic frame_err_q, frame_err_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    feat_d = feat_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    frame_err_d = 1'b0;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      LOAD: if (in_valid) begin
        feat_d[idx_q] = in_data;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          cnt_d = '0;
          state_d = SETTLE;
          frame_err_d = !in_last;
        end else if (in_last) begin
          idx_d = '0;
          frame_err_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + SC_W'(1);
        if (cnt_q == CNT_LAST) begin
          out_class_d = cls_out;
          out_valid_d = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: if (out_ready) begin
        out_valid_d = 1'b0;
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NUM_A; i++) feat_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      frame_err_q <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      feat_q <= feat_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      frame_err_q <= frame_err_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end
  for (genvar i = 0; i < NUM_A; i++) begin : g_pack
    assign cls_inp[i*WIDTH_A +: WIDTH_A] = feat_q[i];
  end
  assign in_ready = state_q == LOAD;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign frame_err = frame_err_q;
  assign sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_mlp_stream_frontend.sv
// tb_mlp_stream_frontend: randomized bench with a stub classifier and a reference model
// of the framing, latency and counting rules; a CNT_W=4 twin exercises counter wrap.
module tb_mlp_stream_frontend;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0, in_last = 0, out_ready = 1;
  logic [3:0] in_data = 0;
  logic in_ready, out_valid, frame_err;
  logic [63:0] cls_inp;
  logic [3:0] cls_out, out_class, stub_cls, const_cls = 0;
  logic [15:0] sample_cnt;
  logic in_ready4, out_valid4, frame_err4;
  logic [63:0] cls_inp4;
  logic [3:0] out_class4, sample_cnt4;
  logic use_const = 0;
  int checks = 0, errors = 0, cyc = 0, ferr_cnt = 0, exp_cnt = 0;
  int feats [16];

  mlp_stream_frontend #(.SETTLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .cls_inp(cls_inp), .cls_out(cls_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .frame_err(frame_err), .sample_cnt(sample_cnt));
  mlp_stream_frontend #(.SETTLE_CYCLES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_last(in_last), .cls_inp(cls_inp4), .cls_out(cls_out), .out_valid(out_valid4),
    .out_ready(out_ready), .out_class(out_class4), .frame_err(frame_err4), .sample_cnt(sample_cnt4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_err) ferr_cnt <= ferr_cnt + 1;

  // Stand-in for the combinational MLP: weighted feature sum modulo ten classes.
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += (i + 1) * int'(cls_inp[i*4 +: 4]);
    stub_cls = 4'(s % 10);
  end
  assign cls_out = use_const ? const_cls : stub_cls;

  function automatic logic [3:0] model_class();
    int s = 0;
    foreach (feats[i]) s += (i + 1) * feats[i];
    return 4'(s % 10);
  endfunction

  function automatic logic [63:0] model_pack(input int n);
    logic [63:0] p = 0;
    for (int i = 0; i < n; i++) p |= 64'(feats[i]) << (4 * i);
    return p;
  endfunction

  task automatic send_beat(input int d, input logic last);
    logic acc;
    int n = 0;
    in_valid = 1; in_data = 4'(d); in_last = last;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_accept got in_ready=0 for %0d cycles want 1", n);
    end
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_beat(feats[i], i == last_at);
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (out_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_valid got out_valid=0 want 1 within 50 cycles"); end
  endtask

  task automatic rand_feats();
    foreach (feats[i]) feats[i] = $urandom_range(0, 15);
  endtask

  task automatic run_result(input logic [3:0] exp_cls, input int stall);
    logic ok;
    wait_valid(ok);
    checks++; if (out_class !== exp_cls) begin errors++; $display("FAIL result_class got %0d want %0d", out_class, exp_cls); end
    checks++; if (cls_inp !== model_pack(16)) begin errors++; $display("FAIL result_pack got %h want %h", cls_inp, model_pack(16)); end
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1;
    @(posedge clk); #1;
    exp_cnt++;
    checks++; if (sample_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sample_cnt got %0d want %0d", sample_cnt, exp_cnt); end
    checks++; if (sample_cnt4 !== 4'(exp_cnt)) begin errors++; $display("FAIL sample_cnt4 got %0d want %0d", sample_cnt4, exp_cnt % 16); end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_class !== 0) begin errors++; $display("FAIL reset_out_class got %0d want 0", out_class); end
    checks++; if (frame_err !== 0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (sample_cnt !== 0) begin errors++; $display("FAIL reset_sample_cnt got %0d want 0", sample_cnt); end
    checks++; if (cls_inp !== 0) begin errors++; $display("FAIL reset_cls_inp got %h want 0", cls_inp); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int k;
    logic ok;
    use_const = 1; const_cls = 4'd3; out_ready = 1;
    foreach (feats[i]) feats[i] = 0;
    feats[0] = 15; feats[15] = 7;
    send_frame(16, 15);
    k = cyc;
    wait_valid(ok);
    checks++; if (cyc !== k + 4) begin errors++; $display("FAIL nominal_latency got %0d want %0d", cyc - k, 4); end
    checks++; if (out_class !== 4'd3) begin errors++; $display("FAIL nominal_class got %0d want 3", out_class); end
    checks++; if (cls_inp[3:0] !== 4'hF) begin errors++; $display("FAIL nominal_feat0 got %h want f", cls_inp[3:0]); end
    checks++; if (cls_inp[63:60] !== 4'h7) begin errors++; $display("FAIL nominal_feat15 got %h want 7", cls_inp[63:60]); end
    @(posedge clk); #1;
    exp_cnt++;
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL nominal_cnt got %0d want 1", sample_cnt); end
    checks++; if (out_valid !== 0 || in_ready !== 1) begin errors++; $display("FAIL nominal_release got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL nominal_ferr got %0d want 0", ferr_cnt); end
    use_const = 0;
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [3:0] cls;
    logic [63:0] held;
    rand_feats();
    out_ready = 0;
    send_frame(16, 15);
    wait_valid(ok);
    cls = model_class();
    held = cls_inp;
    in_valid = 1; in_data = ~4'(feats[0]);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_class !== cls || out_valid !== 1 || in_ready !== 0 || cls_inp !== held) begin
        errors++;
        $display("FAIL stall_hold got class=%0d valid=%b ready=%b want class=%0d valid=1 ready=0", out_class, out_valid, in_ready, cls);
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    exp_cnt++;
    checks++; if (sample_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", sample_cnt, exp_cnt); end
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL stall_release got %b want 0", out_valid); end
  endtask

  task automatic test_early_last();
    int f0 = ferr_cnt;
    logic seen = 0;
    rand_feats();
    send_frame(5, 4);
    for (int i = 0; i < 8; i++) begin
      seen |= out_valid | !in_ready;
      @(posedge clk); #1;
    end
    checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL early_ferr got %0d want %0d", ferr_cnt - f0, 1); end
    checks++; if (seen) begin errors++; $display("FAIL early_no_result got activity=1 want 0"); end
    rand_feats();
    send_frame(16, 15);
    run_result(model_class(), 0);
    checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL early_clean_ferr got %0d want 1", ferr_cnt - f0); end
  endtask

  task automatic test_missing_last();
    int f0 = ferr_cnt;
    rand_feats();
    send_frame(16, -1);
    @(negedge clk); #1;
    checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL missing_ferr got %0d want 1", ferr_cnt - f0); end
    run_result(model_class(), 2);
  endtask

  task automatic test_reset_settle();
    rand_feats();
    send_frame(16, 15);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 0 || frame_err !== 0 || out_class !== 0) begin errors++; $display("FAIL rst_mid_out got valid=%b err=%b class=%0d want 0", out_valid, frame_err, out_class); end
    checks++; if (sample_cnt !== 0 || sample_cnt4 !== 0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", sample_cnt); end
    checks++; if (cls_inp !== 0) begin errors++; $display("FAIL rst_mid_inp got %h want 0", cls_inp); end
    exp_cnt = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    repeat (6) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL rst_mid_discard got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 300; s++) begin
      rand_feats();
      out_ready = $urandom_range(0, 1);
      send_frame(16, 15);
      run_result(model_class(), $urandom_range(0, 3));
      if (s == 16) begin
        checks++; if (sample_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap17 got %0d want 1", sample_cnt4); end
      end
    end
    checks++; if (sample_cnt !== 16'd300) begin errors++; $display("FAIL random_total got %0d want 300", sample_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_settle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
